// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite motor-control master.
package axil_master_pkg;

    // One transaction in flight: write goes IDLE->WR->WB->RSP, read goes IDLE->AR->RD->RSP.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        AR   = 3'd3,
        RD   = 3'd4,
        RSP  = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] WSTRB_ALL   = 4'b1111;

endpackage

// File: rtl/axil_motor_master.sv
// AXI4-Lite single-outstanding master bridging a command/response port to the
// motor control register block. All AXI valids/readies come from flops.
// Optional macro AXIL_MASTER_TIMEOUT_EN: per-phase wait limit of TIMEOUT_CYCLES,
// after which the transaction completes locally with a SLVERR response.
module axil_motor_master
    import axil_master_pkg::*;
#(
    parameter int ADDR_W         = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              s_axi_clk,
    input  logic              rst_n,
    // command / response
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    // AW
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    // W
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    // B
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    // AR
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    // R
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [31:0]         wdata_nxt;
    logic                awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic                rsp_valid_nxt;
    logic [31:0]         rsp_rdata_nxt;
    logic [1:0]          rsp_resp_nxt;

    // Captured address serves both AW and AR; only one channel is ever valid.
    assign m_axi_awaddr = addr;
    assign m_axi_araddr = addr;
    assign m_axi_wstrb  = m_axi_wvalid ? WSTRB_ALL : 4'b0000;
    assign cmd_ready    = (state == IDLE) && rst_n;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;

    assign in_wait = (state == WR) || (state == WB) || (state == AR) || (state == RD);

    // Wait counter restarts on every state change and saturates at the limit.
    always_ff @(posedge s_axi_clk) begin
        if (!rst_n || (state_nxt != state))
            wait_cnt <= '0;
        else if (wait_cnt != CNT_LAST)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    // No timeout hardware: the FSM waits on the responder indefinitely.
    if (TIMEOUT_CYCLES < 1) begin : g_unused_timeout
    end
`endif

    // FSM state register.
    always_ff @(posedge s_axi_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        wdata_nxt     = m_axi_wdata;
        awvalid_nxt   = m_axi_awvalid;
        wvalid_nxt    = m_axi_wvalid;
        bready_nxt    = m_axi_bready;
        arvalid_nxt   = m_axi_arvalid;
        rready_nxt    = m_axi_rready;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_resp_nxt  = rsp_resp;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_nxt  = cmd_addr;
                    wdata_nxt = cmd_wdata;
                    if (cmd_write) begin
                        state_nxt   = WR;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else begin
                        state_nxt   = AR;
                        arvalid_nxt = 1'b1;
                    end
                end
            end
            WR: begin
                // AW and W complete independently; leave once both are done.
                if (m_axi_awready) awvalid_nxt = 1'b0;
                if (m_axi_wready)  wvalid_nxt  = 1'b0;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    state_nxt  = WB;
                    bready_nxt = 1'b1;
                end
            end
            WB: begin
                if (m_axi_bvalid) begin
                    state_nxt     = RSP;
                    bready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_resp_nxt  = m_axi_bresp;
                end
            end
            AR: begin
                if (m_axi_arready) begin
                    state_nxt   = RD;
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                end
            end
            RD: begin
                if (m_axi_rvalid) begin
                    state_nxt     = RSP;
                    rready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = m_axi_rdata;
                    rsp_resp_nxt  = m_axi_rresp;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
        // Phase stalled for the full budget: abandon the bus and report SLVERR.
        if (in_wait && (state_nxt == state) && (wait_cnt == CNT_LAST)) begin
            state_nxt     = RSP;
            awvalid_nxt   = 1'b0;
            wvalid_nxt    = 1'b0;
            bready_nxt    = 1'b0;
            arvalid_nxt   = 1'b0;
            rready_nxt    = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = '0;
            rsp_resp_nxt  = RESP_SLVERR;
        end
`endif
    end

    // Registered AXI controls, payloads and response.
    always_ff @(posedge s_axi_clk) begin
        if (!rst_n) begin
            addr          <= '0;
            m_axi_wdata   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
        end else begin
            addr          <= addr_nxt;
            m_axi_wdata   <= wdata_nxt;
            m_axi_awvalid <= awvalid_nxt;
            m_axi_wvalid  <= wvalid_nxt;
            m_axi_bready  <= bready_nxt;
            m_axi_arvalid <= arvalid_nxt;
            m_axi_rready  <= rready_nxt;
            rsp_valid     <= rsp_valid_nxt;
            rsp_rdata     <= rsp_rdata_nxt;
            rsp_resp      <= rsp_resp_nxt;
        end
    end

endmodule

// File: tb/tb_axil_motor_master.sv
// Scoreboard bench for axil_motor_master: directed commands push expected
// responses; a monitor pops and compares on each rsp handshake.
module tb_axil_motor_master;
    localparam int ADDR_W = 3;

    logic              s_axi_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [31:0]       cmd_wdata = '0;
    logic              cmd_ready, rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
    logic              m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [31:0]       m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_awready = 0, m_axi_wready = 0, m_axi_arready = 0;
    logic              m_axi_bvalid = 0, m_axi_rvalid = 0;
    logic [1:0]        m_axi_bresp = 0, m_axi_rresp = 0;
    logic [31:0]       m_axi_rdata = 0;

    always #5 s_axi_clk = ~s_axi_clk;

    axil_motor_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(256)) dut (
        .s_axi_clk(s_axi_clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        int          acc;
        logic [31:0] rdata;
        logic [1:0]  resp;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_err = 0, cyc = 0;
    int   aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0, rsp_n = 0;

    // responder configuration
    int          aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0;
    logic [1:0]  bresp_cfg = 0, rresp_cfg = 0;
    logic [31:0] rdata_cfg = 0;
    bit          resp_clr = 0, spur = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // posedge counter; index of the edge about to come is cyc+1 when read at a negedge
    initial forever begin
        @(posedge s_axi_clk);
        cyc++;
    end

    // AXI responder: drives on negedges; readies after *_lat waiting cycles,
    // B one cycle after both AW and W complete, R one cycle after AR.
    initial begin
        int  aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0;
        bit  aw_got = 0, w_got = 0, ar_got = 0;
        bit  p_aw = 0, p_w = 0, p_b = 0, p_ar = 0, p_r = 0;
        forever begin
            @(negedge s_axi_clk);
            if (p_aw) begin aw_got = 1; aw_hs_n++; end
            if (p_w)  begin w_got = 1;  w_hs_n++;  end
            if (p_b)  begin m_axi_bvalid = 0; b_hs_n++; end
            if (p_ar) begin ar_got = 1; ar_hs_n++; end
            if (p_r)  begin m_axi_rvalid = 0; r_hs_n++; end
            if (resp_clr) begin
                aw_got = 0; w_got = 0; ar_got = 0; b_cnt = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0; resp_clr = 0;
            end
            aw_cnt = m_axi_awvalid ? aw_cnt + 1 : 0;
            w_cnt  = m_axi_wvalid  ? w_cnt + 1  : 0;
            ar_cnt = m_axi_arvalid ? ar_cnt + 1 : 0;
            m_axi_awready = m_axi_awvalid && (aw_cnt > aw_lat);
            m_axi_wready  = m_axi_wvalid  && (w_cnt > w_lat);
            m_axi_arready = m_axi_arvalid && (ar_cnt > ar_lat);
            if (aw_got && w_got && !m_axi_bvalid) begin
                b_cnt++;
                if (b_cnt > b_lat) begin
                    m_axi_bvalid = 1; m_axi_bresp = bresp_cfg;
                    aw_got = 0; w_got = 0; b_cnt = 0;
                end
            end
            if (ar_got && !m_axi_rvalid) begin
                m_axi_rvalid = 1; m_axi_rdata = rdata_cfg; m_axi_rresp = rresp_cfg; ar_got = 0;
            end
            if (spur) begin m_axi_bvalid = 1; m_axi_rvalid = 1; end
            // handshakes that will complete on the coming posedge
            p_aw = m_axi_awvalid && m_axi_awready;
            p_w  = m_axi_wvalid  && m_axi_wready;
            p_b  = m_axi_bvalid  && m_axi_bready;
            p_ar = m_axi_arvalid && m_axi_arready;
            p_r  = m_axi_rvalid  && m_axi_rready;
        end
    end

    // Response monitor: pops the scoreboard on each rsp handshake, checks
    // hold-stability while stalled and first-visible latency.
    initial begin
        bit          pend = 0;
        int          rise = 0;
        logic [31:0] h_rdata;
        logic [1:0]  h_resp;
        exp_t        e;
        forever begin
            @(negedge s_axi_clk);
            #1;
            if (rsp_valid === 1'b1) begin
                if (!pend) begin
                    pend = 1; rise = cyc + 1; h_rdata = rsp_rdata; h_resp = rsp_resp;
                end else begin
                    chk("rsp_rdata_stable", rsp_rdata, h_rdata);
                    chk("rsp_resp_stable", {30'd0, rsp_resp}, {30'd0, h_resp});
                end
                chkb("cmd_ready_during_rsp", cmd_ready, 1'b0);
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_rsp: got rdata 0x%0h resp %0d, expected no response",
                                 rsp_rdata, rsp_resp);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
                        if (e.lat) chk("rsp_latency", rise - e.acc, 3);
                    end
                    pend = 0;
                    rsp_n++;
                end
            end
        end
    end

    // Issue one command starting at a negedge; returns the accept edge index.
    task automatic send(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input logic [1:0] ers, input bit lat,
                        input bit push, output int acc);
        int n = 0;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1;
        while (!cmd_ready && n < 50) begin
            @(negedge s_axi_clk);
            n++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL cmd_accept: cmd_ready stayed 0, expected 1");
            cmd_valid = 0; acc = -1;
            return;
        end
        acc = cyc + 1;
        if (push) exp_q.push_back('{acc, erd, ers, lat});
        @(negedge s_axi_clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int target, input int budget, input string nm);
        int n = 0;
        while (rsp_n < target && n < budget) begin
            @(negedge s_axi_clk);
            n++;
        end
        #2;
        chk(nm, rsp_n, target);
    endtask

    initial begin
        int acc1, acc2, r0, hs0, bh0;
        bit split;
        // watchdog against a hung handshake
        fork
            begin
                repeat (20000) @(posedge s_axi_clk);
                $display("FAIL watchdog: simulation exceeded cycle budget");
                $fatal(1);
            end
        join_none

        // reset state
        repeat (3) @(negedge s_axi_clk);
        #1;
        chkb("rst_cmd_ready", cmd_ready, 1'b0);
        chkb("rst_awvalid", m_axi_awvalid, 1'b0);
        chkb("rst_wvalid", m_axi_wvalid, 1'b0);
        chkb("rst_bready", m_axi_bready, 1'b0);
        chkb("rst_arvalid", m_axi_arvalid, 1'b0);
        chkb("rst_rready", m_axi_rready, 1'b0);
        chkb("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_wdata", m_axi_wdata, 0);
        @(negedge s_axi_clk);
        rst_n = 1;
        #1;
        chkb("cmd_ready_after_rst", cmd_ready, 1'b1);
        @(negedge s_axi_clk);

        // zero-wait write, addr 0, data 20000
        send(1, 0, 32'd20000, 0, 2'b00, 1, 1, acc1);
        #1;
        chkb("wr_awvalid", m_axi_awvalid, 1'b1);
        chkb("wr_wvalid", m_axi_wvalid, 1'b1);
        chk("wr_wstrb", {28'd0, m_axi_wstrb}, 32'hF);
        chk("wr_awaddr", {29'd0, m_axi_awaddr}, 0);
        chk("wr_wdata", m_axi_wdata, 32'd20000);
        wait_rsp(1, 20, "wr_rsp_count");

        // zero-wait read, addr 0, returns 1500
        @(negedge s_axi_clk);
        rdata_cfg = 32'd1500; rresp_cfg = 2'b00;
        send(0, 0, 0, 32'd1500, 2'b00, 1, 1, acc1);
        #1;
        chkb("rd_arvalid", m_axi_arvalid, 1'b1);
        chk("rd_araddr", {29'd0, m_axi_araddr}, 0);
        wait_rsp(2, 20, "rd_rsp_count");

        // back-to-back write then read: error passthrough and 4-cycle spacing
        @(negedge s_axi_clk);
        bresp_cfg = 2'b10; rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b01;
        send(1, 5, 32'h0000_4E20, 0, 2'b10, 1, 1, acc1);
        send(0, 3, 0, 32'hDEAD_BEEF, 2'b01, 1, 1, acc2);
        chk("cmd_spacing", acc2 - acc1, 4);
        wait_rsp(4, 20, "b2b_rsp_count");
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;

        // AW ready two cycles ahead of W ready
        @(negedge s_axi_clk);
        w_lat = 2; bh0 = b_hs_n; hs0 = aw_hs_n; split = 0;
        send(1, 2, 32'h0000_0BB8, 0, 2'b00, 0, 1, acc1);
        for (int i = 0; i < 20 && rsp_n < 5; i++) begin
            #1;
            if (!m_axi_awvalid && m_axi_wvalid) split = 1;
            @(negedge s_axi_clk);
        end
        chkb("aw_drops_w_held", split, 1'b1);
        wait_rsp(5, 20, "split_rsp_count");
        chk("aw_handshakes", aw_hs_n - hs0, 1);
        chk("b_handshakes", b_hs_n - bh0, 1);
        w_lat = 0;

        // response stall: rsp_ready low 5 cycles with a command pending
        @(negedge s_axi_clk);
        rsp_ready = 0; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b00;
        send(0, 1, 0, 32'h1234_5678, 2'b00, 1, 1, acc1);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge s_axi_clk);
        repeat (5) begin
            @(negedge s_axi_clk);
            cmd_valid = 1; cmd_write = 0;
            #1;
            chkb("stall_cmd_ready", cmd_ready, 1'b0);
            chkb("stall_rsp_valid", rsp_valid, 1'b1);
        end
        @(negedge s_axi_clk);
        cmd_valid = 0; rsp_ready = 1;
        wait_rsp(6, 20, "stall_rsp_count");

        // stray bvalid/rvalid while idle produce nothing
        @(negedge s_axi_clk);
        r0 = rsp_n; spur = 1;
        repeat (3) @(negedge s_axi_clk);
        #1;
        chkb("spur_cmd_ready", cmd_ready, 1'b1);
        spur = 0; resp_clr = 1;
        repeat (3) @(negedge s_axi_clk);
        chk("spur_no_rsp", rsp_n, r0);

        // awready never asserted
        aw_lat = 1000000; r0 = rsp_n;
`ifdef AXIL_MASTER_TIMEOUT_EN
        send(1, 4, 32'h0000_0001, 0, 2'b10, 0, 1, acc1);
        wait_rsp(r0 + 1, 400, "timeout_rsp_count");
        aw_lat = 0; resp_clr = 1;
        repeat (2) @(negedge s_axi_clk);
`else
        send(1, 4, 32'h0000_0001, 0, 2'b00, 0, 0, acc1);
        repeat (300) @(negedge s_axi_clk);
        #1;
        chk("no_timeout_no_rsp", rsp_n, r0);
        chkb("no_timeout_awvalid_held", m_axi_awvalid, 1'b1);
        @(negedge s_axi_clk);
        rst_n = 0;
        @(negedge s_axi_clk);
        rst_n = 1; aw_lat = 0; resp_clr = 1;
        repeat (2) @(negedge s_axi_clk);
`endif

        // reset pulse while waiting in WB
        b_lat = 1000000; r0 = rsp_n;
        send(1, 6, 32'h0000_00AA, 0, 2'b00, 0, 0, acc1);
        for (int i = 0; i < 20 && !m_axi_bready; i++) @(negedge s_axi_clk);
        chkb("wb_reached", m_axi_bready, 1'b1);
        rst_n = 0;
        @(negedge s_axi_clk);
        #1;
        chkb("wbrst_bready", m_axi_bready, 1'b0);
        chkb("wbrst_awvalid", m_axi_awvalid, 1'b0);
        chkb("wbrst_rsp_valid", rsp_valid, 1'b0);
        chk("wbrst_awaddr", {29'd0, m_axi_awaddr}, 0);
        chk("wbrst_wdata", m_axi_wdata, 0);
        chkb("wbrst_cmd_ready_low", cmd_ready, 1'b0);
        rst_n = 1; b_lat = 0; resp_clr = 1;
        #1;
        chkb("wbrst_cmd_ready_after", cmd_ready, 1'b1);
        repeat (5) @(negedge s_axi_clk);
        chk("wbrst_no_rsp", rsp_n, r0);

        // normal write after the abandoned one
        send(1, 7, 32'hFFFF_FFFF, 0, 2'b00, 1, 1, acc1);
        wait_rsp(r0 + 1, 20, "post_rst_rsp_count");

        repeat (3) @(negedge s_axi_clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axil_motor_master.md
AXIL_MOTOR_MASTER -- requirements
Module: axil_motor_master

Interface
REQ-001 Parameter ADDR_W, default 3: AXI4-Lite address width; matches the motor control register map.
REQ-002 Parameter TIMEOUT_CYCLES, default 256: maximum wait cycles per AXI phase; used only with the timeout feature.
REQ-003 s_axi_clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  ADDR_W  target register address.
REQ-009 cmd_wdata  input  32  write data (PWM period/duty).
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed.
REQ-012 rsp_rdata  output  32  read data (motor speed); 0 for writes.
REQ-013 rsp_resp  output  2  bresp/rresp of the transaction, or 2'b10 on timeout.
REQ-014 m_axi_awaddr  output  ADDR_W; m_axi_awvalid  output  1; m_axi_awready  input  1: AW channel.
REQ-015 m_axi_wdata  output  32; m_axi_wstrb  output  4; m_axi_wvalid  output  1; m_axi_wready  input  1: W channel.
REQ-016 m_axi_bresp  input  2; m_axi_bvalid  input  1; m_axi_bready  output  1: B channel.
REQ-017 m_axi_araddr  output  ADDR_W; m_axi_arvalid  output  1; m_axi_arready  input  1: AR channel.
REQ-018 m_axi_rdata  input  32; m_axi_rresp  input  2; m_axi_rvalid  input  1; m_axi_rready  output  1: R channel.

Function
REQ-019 FSM states: IDLE, WR (AW/W), WB, AR, RD, RSP. cmd_ready = (state==IDLE) and rst_n high. Only one transaction is outstanding; cmd_addr and cmd_wdata are captured on acceptance.
REQ-020 Write path: on acceptance, go to WR. In the next cycle, awvalid and wvalid both go high with captured addr/data and wstrb=4'b1111. Each valid and its payload stay stable until that channel's ready is sampled high, then that valid drops independently. When both handshakes are done, go to WB.
REQ-021 WB: bready=1 until bvalid is sampled; capture bresp; bready drops; go to RSP with rsp_rdata=0.
REQ-022 Read path: on acceptance, go to AR. arvalid=1 with araddr stable until arready, then go to RD. RD: rready=1 until rvalid is sampled; capture rdata/rresp; go to RSP.
REQ-023 RSP: rsp_valid=1, with rsp_rdata/rsp_resp stable until rsp_ready is sampled. Then return to IDLE, and cmd_ready is high the next cycle.
REQ-024 All AXI valids/readies are registered; no combinational path from any ready/valid input to any output.
REQ-025 Latency with a zero-wait responder: rsp_valid is high 3 cycles after the accept edge for both reads and writes. Minimum spacing between accepted commands is 4 cycles.
REQ-026 bvalid/rvalid/readies sampled outside their own wait state are ignored and produce no response.

Reset
REQ-027 rst_n low forces: state IDLE; all m_axi valids, bready, rready, rsp_valid low; rsp_rdata=0; rsp_resp=0; addr/data outputs 0. Reset mid-transaction abandons it with no response.

Configuration
REQ-028 Macro AXIL_MASTER_TIMEOUT_EN defined: a wait counter clears on entry to WR/WB/AR/RD. If the phase is still incomplete after TIMEOUT_CYCLES cycles, all AXI valids/readies drop and the FSM goes to RSP with rsp_resp=2'b10 and rsp_rdata=0.
REQ-029 Macro undefined: no counter; the FSM waits indefinitely and TIMEOUT_CYCLES is unused.

Structure
REQ-030 Package axil_master_pkg holds the FSM state enum and the constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and WSTRB_ALL=4'b1111. The block is one flat module with no sub-module.

Verification
REQ-031 Write addr 0, data 20000, zero-wait responder: AW/W asserted together, wstrb=4'hF; rsp_valid 3 cycles after accept with resp 0 and rdata 0.
REQ-032 Read addr 0, responder returns rdata=1500, rresp=0: rsp_rdata=1500 and rsp_valid 3 cycles after accept.
REQ-033 awready 2 cycles before wready: awvalid drops after its handshake, wvalid stays held, and there is exactly one bready handshake.
REQ-034 rsp_ready held low for 5 cycles: rsp_valid/rsp_rdata stay stable, cmd_ready stays 0, and a pending cmd is not accepted.
REQ-035 With macro: awready never asserted, so rsp_valid occurs with resp 2'b10 after 256 wait cycles. Without macro: no response.
REQ-036 rst_n pulsed low during WB: all outputs reach reset values the next cycle, no rsp_valid is produced, and cmd_ready=1 after release.
